// File: rtl/card_auth_pkg.sv
// Shared types for the card authorization responder: card network codes,
// responder FSM states and the PIN lockout threshold.
package card_auth_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        VISA = 2'b01,
        MC   = 2'b10,
        AMEX = 2'b11
    } card_t;

    typedef enum logic [2:0] {
        IDLE,
        PIN_COLLECT,
        PIN_CHECK,
        AUTH_WAIT,
        RESULT
    } auth_state_t;

    // Consecutive PIN failures that lock a network (CARD_LOCKOUT_EN builds).
    localparam logic [1:0] LOCK_THRESHOLD = 2'd3;

endpackage

// File: rtl/pin_collector.sv
// Keypad digit collector: shifts BCD digits into a PIN register, counts them,
// flags any non-BCD digit and times out when the keypad goes quiet.
module pin_collector #(
    parameter int PIN_DIGITS    = 4,
    parameter int DIGIT_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    active,
    input  logic                    digit_valid,
    input  logic [3:0]              digit,
    output logic                    done,
    output logic                    timeout,
    output logic                    bad,
    output logic [4*PIN_DIGITS-1:0] pin_value
);

    localparam int PIN_W = 4 * PIN_DIGITS;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int TO_W  = (DIGIT_TIMEOUT > 1) ? $clog2(DIGIT_TIMEOUT + 1) : 1;

    logic [PIN_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             bad_q, bad_d;

    // The final digit completes the PIN; a quiet keypad for DIGIT_TIMEOUT cycles aborts it.
    assign done      = active && digit_valid && (cnt_q == CNT_W'(PIN_DIGITS - 1));
    assign timeout   = active && !digit_valid && (to_q == TO_W'(DIGIT_TIMEOUT - 1));
    assign bad       = bad_q;
    assign pin_value = shreg_q;

    // Next-state: shift a digit in, or age the idle counter while collecting.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        bad_d   = bad_q;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
            to_d    = '0;
            bad_d   = 1'b0;
        end else if (active) begin
            if (digit_valid) begin
                shreg_d = (shreg_q << 4) | PIN_W'(digit);
                cnt_d   = cnt_q + 1'b1;
                to_d    = '0;
                if (digit > 4'd9) begin
                    bad_d = 1'b1;
                end
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    // Collector state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            bad_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            bad_q   <= bad_d;
        end
    end

endmodule

// File: rtl/card_auth_responder.sv
// Terminal-side responder for the payment controller handshake: PIN check and
// per-network credit authorization, answered with one-cycle result pulses.
// Optional macro CARD_LOCKOUT_EN: three consecutive PIN failures lock a network
// until reset (locked PIN inits and authorizations fail immediately).
// Handshake: init strobes and process_abort are single-cycle requests sampled
// only in IDLE (abort in any state); each accepted request yields exactly one
// result pulse unless aborted.
module card_auth_responder
    import card_auth_pkg::*;
#(
    parameter int                PIN_DIGITS    = 4,
    parameter int                AMT_W         = 16,
    parameter int                AUTH_LATENCY  = 8,
    parameter int                DIGIT_TIMEOUT = 255,
    parameter logic [AMT_W-1:0] CREDIT_INIT   = AMT_W'(5000)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              card_choice,
    input  logic                    pin_process_init,
    input  logic                    pymt_process_init,
    input  logic                    process_abort,
    input  logic                    digit_valid,
    input  logic [3:0]              digit,
    input  logic [4*PIN_DIGITS-1:0] pin_ref,
    input  logic [AMT_W-1:0]        pymt_amt,
    output logic                    digit_ready,
    output logic                    busy,
    output logic                    pin_success,
    output logic                    pin_fail,
    output logic                    transaction_success,
    output logic                    transaction_fail,
    output logic [AMT_W-1:0]        credit_out
);

    localparam int PIN_W = 4 * PIN_DIGITS;
    localparam int LAT_W = (AUTH_LATENCY > 1) ? $clog2(AUTH_LATENCY) : 1;

    auth_state_t              state_q, state_d;
    card_t                    card_reg_q, card_reg_d;
    // Index 0 (no card) is held at zero so credit_out reads 0 with no card latched.
    logic [3:0][AMT_W-1:0]    credit_q, credit_d;
    logic [AMT_W-1:0]         amt_q, amt_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic                     force_fail_q, force_fail_d;
    logic                     pin_success_q, pin_success_d;
    logic                     pin_fail_q, pin_fail_d;
    logic                     txn_success_q, txn_success_d;
    logic                     txn_fail_q, txn_fail_d;
    logic                     start_pin, locked, auth_ok;
    logic                     col_done, col_timeout, col_bad;
    logic [PIN_W-1:0]         col_pin;

    pin_collector #(
        .PIN_DIGITS    (PIN_DIGITS),
        .DIGIT_TIMEOUT (DIGIT_TIMEOUT)
    ) u_pin_collector (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_pin | process_abort),
        .active      (state_q == PIN_COLLECT),
        .digit_valid (digit_valid),
        .digit       (digit),
        .done        (col_done),
        .timeout     (col_timeout),
        .bad         (col_bad),
        .pin_value   (col_pin)
    );

`ifdef CARD_LOCKOUT_EN
    logic [3:0][1:0] fail_cnt_q, fail_cnt_d;

    assign locked = (fail_cnt_q[card_reg_q] == LOCK_THRESHOLD);

    // Track consecutive PIN failures of the latched network, saturating at the lock count.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (card_reg_q != NONE) begin
            if (pin_success_q) begin
                fail_cnt_d[card_reg_q] = 2'd0;
            end else if (pin_fail_q && (fail_cnt_q[card_reg_q] != LOCK_THRESHOLD)) begin
                fail_cnt_d[card_reg_q] = fail_cnt_q[card_reg_q] + 2'd1;
            end
        end
    end

    // Fail counters survive aborts; only reset unlocks a network.
    always_ff @(posedge clk) begin
        if (reset) begin
            fail_cnt_q <= '0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end
`else
    assign locked = 1'b0;
`endif

    assign auth_ok             = (card_reg_q != NONE) && !locked && (amt_q <= credit_q[card_reg_q]);
    assign digit_ready         = (state_q == PIN_COLLECT);
    assign busy                = (state_q != IDLE);
    assign pin_success         = pin_success_q;
    assign pin_fail            = pin_fail_q;
    assign transaction_success = txn_success_q;
    assign transaction_fail    = txn_fail_q;
    assign credit_out          = credit_q[card_reg_q];

    // Card register: new selection loads, abort or a transaction result clears it.
    always_comb begin
        card_reg_d = card_reg_q;
        if (txn_success_q || txn_fail_q) begin
            card_reg_d = NONE;
        end
        if (card_choice != 2'b00) begin
            card_reg_d = card_t'(card_choice);
        end
        if (process_abort) begin
            card_reg_d = NONE;
        end
    end

    // Responder FSM next-state, result pulses and credit update; abort overrides all.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        amt_d         = amt_q;
        lat_d         = lat_q;
        force_fail_d  = force_fail_q;
        pin_success_d = 1'b0;
        pin_fail_d    = 1'b0;
        txn_success_d = 1'b0;
        txn_fail_d    = 1'b0;
        start_pin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pin_process_init) begin
                    if (locked) begin
                        state_d      = PIN_CHECK;
                        force_fail_d = 1'b1;
                    end else begin
                        state_d   = PIN_COLLECT;
                        start_pin = 1'b1;
                    end
                end else if (pymt_process_init) begin
                    state_d = AUTH_WAIT;
                    amt_d   = pymt_amt;
                    lat_d   = LAT_W'(AUTH_LATENCY - 1);
                end
            end
            PIN_COLLECT: begin
                if (col_timeout) begin
                    state_d    = RESULT;
                    pin_fail_d = 1'b1;
                end else if (col_done) begin
                    state_d      = PIN_CHECK;
                    force_fail_d = 1'b0;
                end
            end
            PIN_CHECK: begin
                state_d      = RESULT;
                force_fail_d = 1'b0;
                if (!force_fail_q && !col_bad && (col_pin == pin_ref)) begin
                    pin_success_d = 1'b1;
                end else begin
                    pin_fail_d = 1'b1;
                end
            end
            AUTH_WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESULT;
                    if (auth_ok) begin
                        txn_success_d        = 1'b1;
                        credit_d[card_reg_q] = credit_q[card_reg_q] - amt_q;
                    end else begin
                        txn_fail_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (process_abort) begin
            state_d       = IDLE;
            credit_d      = credit_q;
            lat_d         = '0;
            force_fail_d  = 1'b0;
            start_pin     = 1'b0;
            pin_success_d = 1'b0;
            pin_fail_d    = 1'b0;
            txn_success_d = 1'b0;
            txn_fail_d    = 1'b0;
        end
    end

    // Responder state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            card_reg_q    <= NONE;
            credit_q      <= {CREDIT_INIT, CREDIT_INIT, CREDIT_INIT, AMT_W'(0)};
            amt_q         <= '0;
            lat_q         <= '0;
            force_fail_q  <= 1'b0;
            pin_success_q <= 1'b0;
            pin_fail_q    <= 1'b0;
            txn_success_q <= 1'b0;
            txn_fail_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            card_reg_q    <= card_reg_d;
            credit_q      <= credit_d;
            amt_q         <= amt_d;
            lat_q         <= lat_d;
            force_fail_q  <= force_fail_d;
            pin_success_q <= pin_success_d;
            pin_fail_q    <= pin_fail_d;
            txn_success_q <= txn_success_d;
            txn_fail_q    <= txn_fail_d;
        end
    end

endmodule

// File: tb/tb_card_auth_responder.sv
// Bench for card_auth_responder: directed sessions push expected result pulses
// into a queue; a negedge monitor pops and compares each pulse as it appears.
module tb_card_auth_responder;

    localparam int AMT_W         = 16;
    localparam int PIN_DIGITS    = 4;
    localparam int AUTH_LATENCY  = 8;
    localparam int DIGIT_TIMEOUT = 255;
    // Expected entry: {first_cycle[32], last_cycle[32], pulses[4], check_credit, credit[16]}
    localparam int W = 85;

    localparam logic [3:0] P_PS = 4'b1000;
    localparam logic [3:0] P_PF = 4'b0100;
    localparam logic [3:0] P_TS = 4'b0010;
    localparam logic [3:0] P_TF = 4'b0001;

    logic             clk;
    logic             reset;
    logic [1:0]       card_choice;
    logic             pin_process_init;
    logic             pymt_process_init;
    logic             process_abort;
    logic             digit_valid;
    logic [3:0]       digit;
    logic [15:0]      pin_ref;
    logic [AMT_W-1:0] pymt_amt;
    logic             digit_ready;
    logic             busy;
    logic             pin_success;
    logic             pin_fail;
    logic             transaction_success;
    logic             transaction_fail;
    logic [AMT_W-1:0] credit_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [3:0]   mon_p;

    int         credit_m[4];
    int         fail_m[4];
    logic [1:0] card_m;

    card_auth_responder dut (
        .clk                 (clk),
        .reset               (reset),
        .card_choice         (card_choice),
        .pin_process_init    (pin_process_init),
        .pymt_process_init   (pymt_process_init),
        .process_abort       (process_abort),
        .digit_valid         (digit_valid),
        .digit               (digit),
        .pin_ref             (pin_ref),
        .pymt_amt            (pymt_amt),
        .digit_ready         (digit_ready),
        .busy                (busy),
        .pin_success         (pin_success),
        .pin_fail            (pin_fail),
        .transaction_success (transaction_success),
        .transaction_fail    (transaction_fail),
        .credit_out          (credit_out)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mk(input int lo, input int hi, input logic [3:0] p,
                                        input logic chk, input int cr);
        return {32'(lo), 32'(hi), p, chk, 16'(cr)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every result pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            mon_p = {pin_success, pin_fail, transaction_success, transaction_fail};
            if (mon_p != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got %b at cycle %0d, expected none", mon_p, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind", int'(mon_p), int'(mon_e[20:17]));
                    n_vec++;
                    if (cyc < int'(mon_e[84:53]) || cyc > int'(mon_e[52:21])) begin
                        n_err++;
                        $display("FAIL pulse_cycle: got %0d, expected %0d..%0d",
                                 cyc, mon_e[84:53], mon_e[52:21]);
                    end
                    if (mon_e[16]) begin
                        check("credit_out", int'(credit_out), int'(mon_e[15:0]));
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        card_choice       = 2'b00;
        pin_process_init  = 1'b0;
        pymt_process_init = 1'b0;
        process_abort     = 1'b0;
        digit_valid       = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            step();
            if (exp_q.size() == 0 && !busy) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_idle: got busy=%0d pending=%0d, expected idle", busy, exp_q.size());
        exp_q.delete();
    endtask

    function automatic logic locked_m();
`ifdef CARD_LOCKOUT_EN
        return (card_m != 2'b00) && (fail_m[card_m] == 3);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void pin_result_m(input logic ok);
`ifdef CARD_LOCKOUT_EN
        if (card_m != 2'b00) begin
            if (ok) fail_m[card_m] = 0;
            else if (fail_m[card_m] < 3) fail_m[card_m] = fail_m[card_m] + 1;
        end
`else
        if (ok) fail_m[0] = 0;
`endif
    endfunction

    task automatic select_card(input logic [1:0] c);
        step();
        card_choice = c;
        step();
        card_m = c;
    endtask

    task automatic pin_session(input logic [15:0] digs, input logic [15:0] refv,
                               input int gap, input logic also_pay);
        logic ok;
        int   c0;
        step();
        pin_ref          = refv;
        pin_process_init = 1'b1;
        if (also_pay) begin
            pymt_process_init = 1'b1;
            pymt_amt          = 16'd100;
        end
        c0 = cyc;
        if (locked_m()) begin
            exp_q.push_back(mk(c0 + 2, c0 + 2, P_PF, 1'b0, 0));
            pin_result_m(1'b0);
            step();
            check("digit_ready_locked", int'(digit_ready), 0);
            wait_idle();
            return;
        end
        ok = (digs == refv);
        for (int i = 0; i < 4; i++) begin
            if (digs[15-4*i -: 4] > 4'd9) ok = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) check("digit_ready", int'(digit_ready), 1);
            digit_valid = 1'b1;
            digit       = digs[15-4*i -: 4];
            if (i == 3) exp_q.push_back(mk(cyc + 2, cyc + 2, ok ? P_PS : P_PF, 1'b0, 0));
            else repeat (gap) step();
        end
        pin_result_m(ok);
        wait_idle();
    endtask

    task automatic pay(input int amt);
        logic ok;
        int   c0;
        int   cr;
        step();
        pymt_amt          = 16'(amt);
        pymt_process_init = 1'b1;
        c0 = cyc;
        ok = (card_m != 2'b00) && !locked_m() && (amt <= credit_m[card_m]);
        if (ok) credit_m[card_m] = credit_m[card_m] - amt;
        cr = (card_m != 2'b00) ? credit_m[card_m] : 0;
        exp_q.push_back(mk(c0 + AUTH_LATENCY + 1, c0 + AUTH_LATENCY + 1,
                           ok ? P_TS : P_TF, 1'b1, cr));
        wait_idle();
        card_m = 2'b00;
    endtask

    task automatic timeout_session();
        int c0;
        step();
        pin_process_init = 1'b1;
        c0 = cyc;
        exp_q.push_back(mk(c0 + DIGIT_TIMEOUT, c0 + DIGIT_TIMEOUT + 2, P_PF, 1'b0, 0));
        pin_result_m(1'b0);
        wait_idle();
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        reset             = 1'b1;
        card_choice       = 2'b00;
        pin_process_init  = 1'b0;
        pymt_process_init = 1'b0;
        process_abort     = 1'b0;
        digit_valid       = 1'b0;
        digit             = 4'd0;
        pin_ref           = 16'h0000;
        pymt_amt          = '0;
        card_m            = 2'b00;
        for (int i = 0; i < 4; i++) begin
            credit_m[i] = (i == 0) ? 0 : 5000;
            fail_m[i]   = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_busy", int'(busy), 0);
        check("rst_digit_ready", int'(digit_ready), 0);
        check("rst_pulses", int'({pin_success, pin_fail, transaction_success, transaction_fail}), 0);
        check("rst_credit_out", int'(credit_out), 0);

        // Visa PIN sessions: wrong digit, non-BCD digit, correct PIN with keypad gaps
        select_card(2'b01);
        check("visa_credit", int'(credit_out), 5000);
        pin_session(16'h1235, 16'h1234, 0, 1'b0);
        pin_session(16'h1A34, 16'h1A34, 0, 1'b0);
        pin_session(16'h1234, 16'h1234, 5, 1'b0);

        // Mastercard authorizations
        select_card(2'b10);
        pay(1200);
        select_card(2'b10);
        pay(4000);
        pay(100);

        // Keypad timeout
        select_card(2'b01);
        timeout_session();

        // Abort after two digits
        select_card(2'b01);
        step();
        pin_ref          = 16'h1234;
        pin_process_init = 1'b1;
        step();
        digit_valid = 1'b1;
        digit       = 4'd1;
        step();
        digit_valid = 1'b1;
        digit       = 4'd2;
        step();
        process_abort = 1'b1;
        step();
        card_m = 2'b00;
        check("abort_busy", int'(busy), 0);
        check("abort_credit_out", int'(credit_out), 0);
        repeat (4) step();

        // Simultaneous inits: PIN wins, payment dropped
        select_card(2'b01);
        pin_session(16'h1234, 16'h1234, 0, 1'b1);
        check("dual_init_credit", int'(credit_out), credit_m[1]);

        // Amex: three wrong PINs, then a correct PIN and a payment
        select_card(2'b11);
        pin_session(16'h1111, 16'h1234, 0, 1'b0);
        pin_session(16'h1111, 16'h1234, 0, 1'b0);
        pin_session(16'h1111, 16'h1234, 0, 1'b0);
        pin_session(16'h1234, 16'h1234, 0, 1'b0);
        pay(100);

        // Visa path after the amex failures
        select_card(2'b01);
        pin_session(16'h1234, 16'h1234, 0, 1'b0);
        pay(250);

        // Boundaries: exact remaining credit, then a zero amount
        select_card(2'b10);
        pay(3800);
        select_card(2'b10);
        pay(0);

        repeat (5) step();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/card_auth_responder.md
Name: card_auth_responder

Overview:
- Terminal-side responder for the credit card payment controller handshake.
- Accepts the controller's init strobes: card_choice, pin_process_init, pymt_process_init and process_abort.
- Collects PIN digits from the keypad and checks them against the card's reference PIN.
- Authorizes the payment amount against a per-network available-credit register.
- Returns single-cycle result pulses: pin_success/pin_fail and transaction_success/transaction_fail.

Parameters:
- PIN_DIGITS, 4: BCD digits per PIN.
- AMT_W, 16: payment amount and credit register width.
- AUTH_LATENCY, 8: cycles from authorization start to the result pulse (≥1).
- DIGIT_TIMEOUT, 255: idle cycles allowed between keypad digits before pin_fail.
- CREDIT_INIT, 16'd5000: reset value of every credit register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- card_choice  in  2  01 visa, 10 mastercard, 11 amex, 00 none
- pin_process_init  in  1  start PIN collection
- pymt_process_init  in  1  start payment authorization
- process_abort  in  1  cancel the session
- digit_valid  in  1  keypad digit strobe
- digit  in  4  BCD keypad digit
- pin_ref  in  4*PIN_DIGITS  card's reference PIN, first digit in the MSBs
- pymt_amt  in  AMT_W  amount to authorize
- digit_ready  out  1  high while PIN_COLLECT
- busy  out  1  high whenever state != IDLE
- pin_success  out  1  one-cycle pulse
- pin_fail  out  1  one-cycle pulse
- transaction_success  out  1  one-cycle pulse
- transaction_fail  out  1  one-cycle pulse
- credit_out  out  AMT_W  available credit of the latched card (0 when no card latched)

Behaviour:
- Reset:
  - state=IDLE; card_reg=00; credit[visa/mc/amex]=CREDIT_INIT.
  - Digit shift register, digit count, timeout counter and latency counter cleared.
  - All outputs 0.
- card_reg loads card_choice on any cycle where card_choice != 00. It clears on process_abort and after any transaction result pulse.
- States: IDLE, PIN_COLLECT, PIN_CHECK, AUTH_WAIT, RESULT.
- IDLE:
  - pin_process_init -> PIN_COLLECT; clear digit count and timeout counter.
  - Otherwise pymt_process_init -> AUTH_WAIT; latch pymt_amt; latency counter = AUTH_LATENCY-1.
  - Both inits in the same cycle: PIN wins; the payment init is dropped.
- Init strobes outside IDLE are ignored.
- PIN_COLLECT:
  - Each digit_valid shifts digit in and resets the timeout counter.
  - A digit > 9 sets a sticky bad flag.
  - When the PIN_DIGITS-th digit arrives -> PIN_CHECK.
  - Timeout counter reaching DIGIT_TIMEOUT with no digit -> RESULT with pin_fail.
- PIN_CHECK (1 cycle):
  - If no bad flag and shift register == pin_ref -> pin_success, else pin_fail.
  - Pulse is asserted in the RESULT cycle, which is 2 cycles after the final digit_valid. Then -> IDLE.
- AUTH_WAIT: decrement the latency counter; at 0 evaluate:
  - Success when card_reg != 00 and amt <= credit[card_reg]. credit[card_reg] -= amt in the same cycle.
  - Otherwise fail; credit unchanged.
  - amt=0 with a valid card: success, no change.
  - The result pulse is asserted exactly AUTH_LATENCY+1 cycles after the pymt_process_init cycle.
- RESULT: drive the pending pulse for 1 cycle -> IDLE. Pulses are mutually exclusive.
- process_abort has highest priority in every state:
  - Next state IDLE, no result pulse.
  - Counters and card_reg cleared; credit preserved.
  - A deduction committed in an earlier cycle stands.
- Reset mid-operation restores the full reset state, including credit.
- Arithmetic is unsigned AMT_W; the subtraction never underflows because of the <= check.

Optional Feature:
- Macro: CARD_LOCKOUT_EN.
- When defined:
  - 2-bit consecutive-fail counter per network, incremented on pin_fail and cleared on pin_success.
  - Count 3 locks that network until reset.
  - PIN init on a locked card: pin_fail 2 cycles later without collecting digits (digit_ready stays 0).
  - Authorization on a locked card always fails.
- When undefined: no counters, no locking.

Decomposition:
- Package card_auth_pkg holds:
  - card_t enum: NONE=2'b00, VISA=2'b01, MC=2'b10, AMEX=2'b11.
  - auth_state_t enum.
  - Lockout threshold constant, 3.
- Sub-module pin_collector holds the digit shift register, digit count, bad flag and timeout counter. It outputs done, timeout and the collected PIN value.

Test Plan:
- card_choice=01, pin_process_init, digits 1,2,3,4 with pin_ref=16'h1234 -> pin_success pulse 2 cycles after the 4th digit.
- Same setup, digits 1,2,3,5 -> pin_fail. Digit 4'hA anywhere -> pin_fail.
- card_choice=10, pymt_amt=1200, pymt_process_init -> transaction_success at cycle +9 and credit_out=3800. A second request of 4000 -> transaction_fail, credit stays 3800.
- PIN init with no digits -> pin_fail after DIGIT_TIMEOUT cycles. process_abort after 2 digits -> IDLE, no pulse, busy=0 next cycle.
- pin_process_init and pymt_process_init in the same cycle -> PIN_COLLECT only. pymt_process_init with card_reg=00 -> transaction_fail.
- With CARD_LOCKOUT_EN: 3 wrong PINs on amex -> the 4th init gives an immediate pin_fail, and payment on amex fails. The visa path is unaffected.
